byte_sram_ctrl: RTL and testbench
=================================

Name: byte_sram_ctrl

Overview:
- Parametrised, byte-addressed data memory with a valid/ready request port and a registered response port. Sits between the load/store unit and the storage array.
- Splits the memory into DATA_W/8 byte-lane banks.
- Supports byte enables, configurable read latency, and address wrap-around.
- Can split accesses that cross a word boundary into two beats.

Parameters:
ADDR_W, 16, byte-address width; capacity 2**ADDR_W bytes
DATA_W, 32, data width; multiple of 8, with DATA_W/8 a power of two (NB = DATA_W/8 lanes)
RD_LAT, 1, cycles from the last beat being accepted to rsp_valid; legal range 1..3

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a beat this cycle
req_we  in  1  1 = write, 0 = read
req_be  in  NB  byte enables; bit i controls byte at req_addr+i
req_addr  in  ADDR_W  byte address; need not be aligned
req_wdata  in  DATA_W  write data; byte i goes to req_addr+i
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DATA_W  byte i = mem[req_addr+i]; 0 for writes and errors
rsp_err  out  1  qualified by rsp_valid
busy  out  1  high while in BEAT2 or while any response is in flight

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, FSM=IDLE. req_ready=0 while rst=1 and 1 in the first cycle after release. Array contents are not reset.
- Handshake: a request is accepted when req_valid && req_ready. Inputs are sampled only at acceptance.
- FSM:
  - IDLE: req_ready=1.
  - An aligned access, or one whose enabled bytes all fall in one row, completes in one beat and the FSM stays in IDLE.
  - A crossing access (offset o=req_addr%NB, some be[i]=1 with o+i>=NB), with SRAM_MISALIGN_SPLIT_EN defined, commits lanes o..NB-1 of row r in the accept cycle and moves to BEAT2.
  - BEAT2: req_ready=0. Commits lanes 0..o-1 of row r+1 from the registered request, then returns to IDLE.
- Writes: committed on the rising edge of the beat; only enabled lanes change. A read accepted the next cycle sees the new data.
- Reads: the array is read synchronously each beat. Row r lanes and row r+1 lanes are merged and rotated so that byte i = mem[addr+i]. Disabled bytes still return array data.
- Response timing: rsp_valid asserts RD_LAT cycles after the final beat, via an RD_LAT-deep valid/data pipe.
  - Back-to-back single-beat requests: one accept and one response per cycle.
  - A split request occupies two accept slots.
- Writes also produce a response: rsp_valid=1, rdata=0, err=0.
- Wrap-around: row r+1 is taken modulo 2**ADDR_W/NB, so addr+i wraps to 0.
- req_be=0: no array change; a response with err=0 is still returned.
- Reset mid-operation: pending BEAT2 and in-flight responses are discarded; no rsp_valid is issued for them. Beat-1 bytes already written stay written.

Optional Feature:
SRAM_MISALIGN_SPLIT_EN
- Defined: crossing accesses are split into two beats as described above.
- Undefined: a crossing access makes no array change. It returns rsp_valid after RD_LAT with rsp_err=1 and rsp_rdata=0. req_ready stays 1 and the BEAT2 state is not built.

Test Plan (DATA_W=32, ADDR_W=16):
1. RD_LAT=1: write 0xDEADBEEF @0x0010 be=F, then read @0x0010 be=F -> read response 1 cycle after accept, rdata=0xDEADBEEF, err=0.
2. Write 0x0000AA00 @0x0010 be=0010b, then read @0x0010 -> 0xDEADAAEF.
3. Macro on: write 0x0 @0x0014, then write 0x11223344 @0x0013 be=F -> req_ready=0 for exactly 1 cycle. Read @0x0010 -> 0x44ADAAEF; read @0x0014 -> 0x00112233. Macro off: same write -> rsp_err=1, both words unchanged.
4. Macro on: write 0xA1B2C3D4 @0xFFFE be=F -> bytes D4,C3 at 0xFFFE/0xFFFF and B2,A1 at 0x0000/0x0001. Read @0x0000 (bytes 0x0002/0x0003 unwritten, X) -> rdata[15:0]=0xA1B2.
5. RD_LAT=2: four aligned reads @0x00,0x04,0x08,0x0C with req_valid held -> responses on four consecutive cycles starting 2 cycles after the first accept, in order; busy stays high throughout.
6. Assert rst during BEAT2 of the case-3 write -> rsp_valid=0 immediately, no response afterwards. Byte @0x0013=0x44 is written; @0x0014..0x0016 are unchanged.

Source files
------------

// File: rtl/byte_sram_if.sv
// ---------------------------------------------------------------------------
// byte_sram_if -- request/response bundle between a load/store unit and
// byte_sram_ctrl.
//
//   req_valid / req_ready : beat handshake, accepted when both are high
//   req_we, req_be        : write flag and per-byte enables (bit i -> addr+i)
//   req_addr, req_wdata   : byte address (any alignment) and write data
//   rsp_valid             : one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err    : response data / error, qualified by rsp_valid
//   busy                  : second beat pending or a response in flight
//
// master = load/store side, slave = memory controller side.
// ---------------------------------------------------------------------------
interface byte_sram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NB-1:0]     req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/byte_sram_ctrl.sv
// ---------------------------------------------------------------------------
// byte_sram_ctrl -- byte-addressed data memory built from NB = DATA_W/8
// byte-lane banks, with a valid/ready request side and a pipelined response.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : byte_sram_if.slave (request, response and busy signals)
//
// Parameters:
//   ADDR_W : byte-address width (capacity 2**ADDR_W bytes)
//   DATA_W : data width, multiple of 8 with DATA_W/8 a power of two (>= 2)
//   RD_LAT : cycles from the final beat to rsp_valid, 1..3
//
// Build option:
//   SRAM_MISALIGN_SPLIT_EN -- when defined, an access whose enabled bytes
//   spill past the end of its row is performed as two beats (row r, then
//   row r+1). When undefined such an access is rejected with rsp_err=1 and
//   touches nothing; no second-beat state exists.
//
// Lane j of the array holds byte (row*NB + j). For a request at offset o,
// request byte i lives in lane (o+i)%NB; lanes j >= o use row r and lanes
// j < o use row r+1 (modulo the row count, which gives address wrap).
// ---------------------------------------------------------------------------
module byte_sram_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  byte_sram_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int RA_W  = ADDR_W - OFF_W;
  localparam int ROWS  = 2 ** RA_W;

  // Current beat: either the live request (IDLE) or the captured one (BEAT2)
  logic              in_beat2;
  logic              accept;
  logic              cur_fire;
  logic              cur_we;
  logic [NB-1:0]     cur_be;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [OFF_W-1:0]  cur_off;
  logic [RA_W-1:0]   cur_row;
  logic [RA_W-1:0]   cur_row_next;
  logic              crossing;

`ifdef SRAM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;

  typedef enum logic {IDLE, BEAT2} state_t;

  state_t            state_reg;
  logic              we_reg;
  logic [NB-1:0]     be_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  assign in_beat2 = (state_reg == BEAT2);
`else
  localparam bit SPLIT = 1'b0;

  assign in_beat2 = 1'b0;
`endif

  assign bus.req_ready = !rst && !in_beat2;
  assign accept        = bus.req_valid && bus.req_ready;
  assign cur_fire      = accept || in_beat2;

  always_comb begin
    cur_we    = bus.req_we;
    cur_be    = bus.req_be;
    cur_addr  = bus.req_addr;
    cur_wdata = bus.req_wdata;
`ifdef SRAM_MISALIGN_SPLIT_EN
    if (in_beat2) begin
      cur_we    = we_reg;
      cur_be    = be_reg;
      cur_addr  = addr_reg;
      cur_wdata = wdata_reg;
    end
`endif
  end

  assign cur_off      = cur_addr[OFF_W-1:0];
  assign cur_row      = cur_addr[ADDR_W-1:OFF_W];
  assign cur_row_next = cur_row + RA_W'(1);

  // An access crosses when any enabled byte lands at or beyond the row end
  always_comb begin
    crossing = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (cur_be[i] && (int'(cur_off) + i >= NB)) crossing = 1'b1;
    end
  end

`ifdef SRAM_MISALIGN_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && crossing) begin
            state_reg <= BEAT2;
            we_reg    <= bus.req_we;
            be_reg    <= bus.req_be;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
          end
        end
        BEAT2:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Byte-lane banks. Each lane reads every cycle (registered read); a write
  // lands on a lane only when its byte is enabled and belongs to this beat:
  // single beat -> all enabled lanes, split beat 1 -> lanes >= o,
  // beat 2 -> lanes < o. A rejected crossing access writes nothing.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_word;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0]       mem [ROWS];
    logic [7:0]       q_reg;
    logic             lane_hi;
    logic [OFF_W-1:0] byte_idx;
    logic [RA_W-1:0]  lane_row;
    logic             lane_allow;
    logic             lane_we;

    assign lane_hi    = (OFF_W'(gi) >= cur_off);
    assign byte_idx   = OFF_W'(gi) - cur_off;
    assign lane_row   = lane_hi ? cur_row : cur_row_next;
    assign lane_allow = in_beat2 ? !lane_hi : (!crossing || (SPLIT && lane_hi));
    assign lane_we    = cur_fire && cur_we && cur_be[byte_idx] && lane_allow;

    always_ff @(posedge clk) begin
      if (lane_we) mem[lane_row] <= cur_wdata[8*byte_idx +: 8];
      q_reg <= mem[lane_row];
    end

    assign ram_word[8*gi +: 8] = q_reg;
  end

  // -------------------------------------------------------------------------
  // Response stage 1: launched on the final beat, aligned with the RAM output
  // -------------------------------------------------------------------------
  logic              rsp_issue;
  logic              rsp_err_n;
  logic              v1_reg;
  logic              rd1_reg;
  logic              err1_reg;
  logic [OFF_W-1:0]  off1_reg;
  logic [DATA_W-1:0] stage1_data;
  logic              pipe_busy;

  assign rsp_issue = in_beat2 || (accept && !(crossing && SPLIT));
  assign rsp_err_n = !in_beat2 && crossing && !SPLIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      rd1_reg  <= 1'b0;
      err1_reg <= 1'b0;
      off1_reg <= '0;
    end else begin
      v1_reg   <= rsp_issue;
      rd1_reg  <= rsp_issue && !cur_we && !rsp_err_n;
      err1_reg <= rsp_issue && rsp_err_n;
      off1_reg <= cur_off;
    end
  end

  // Rotate lanes back into request byte order; writes and errors return 0
  always_comb begin
    stage1_data = '0;
    if (rd1_reg) begin
      for (int i = 0; i < NB; i++) begin
        stage1_data[8*i +: 8] = ram_word[8*((i + int'(off1_reg)) % NB) +: 8];
      end
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign bus.rsp_valid = v1_reg;
    assign bus.rsp_rdata = stage1_data;
    assign bus.rsp_err   = err1_reg;
    assign pipe_busy     = 1'b0;
  end else begin : g_latn
    logic [RD_LAT-2:0] v_pipe;
    logic [RD_LAT-2:0] e_pipe;
    logic [DATA_W-1:0] d_pipe [RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_pipe <= '0;
        e_pipe <= '0;
        for (int k = 0; k < RD_LAT - 1; k++) d_pipe[k] <= '0;
      end else begin
        v_pipe[0] <= v1_reg;
        e_pipe[0] <= err1_reg;
        d_pipe[0] <= stage1_data;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          v_pipe[k] <= v_pipe[k-1];
          e_pipe[k] <= e_pipe[k-1];
          d_pipe[k] <= d_pipe[k-1];
        end
      end
    end

    assign bus.rsp_valid = v_pipe[RD_LAT-2];
    assign bus.rsp_rdata = d_pipe[RD_LAT-2];
    assign bus.rsp_err   = e_pipe[RD_LAT-2];
    assign pipe_busy     = |v_pipe;
  end

  assign bus.busy = in_beat2 || v1_reg || pipe_busy;

endmodule

// File: tb/tb_byte_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_byte_sram_ctrl -- directed checks of byte_sram_ctrl (DATA_W=32,
// ADDR_W=16). Instance "dut1" uses RD_LAT=1, "dut2" uses RD_LAT=2 for the
// streaming-read case. Split-beat cases follow SRAM_MISALIGN_SPLIT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_byte_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  byte_sram_if #(.ADDR_W(16), .DATA_W(32)) a ();
  byte_sram_if #(.ADDR_W(16), .DATA_W(32)) b ();

  byte_sram_ctrl #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  byte_sram_ctrl #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on dut1; lat counts negedges after the accept edge until
  // rsp_valid (-1 if none), ready_low counts those cycles with req_ready=0.
  task automatic xfer(input string tag, input logic we, input logic [3:0] be,
                      input logic [15:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int lat, output int ready_low);
    int n;
    @(negedge clk);
    a.req_valid = 1'b1;
    a.req_we    = we;
    a.req_be    = be;
    a.req_addr  = addr;
    a.req_wdata = wdata;
    n = 0;
    while (!a.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    a.req_valid = 1'b0;
    a.req_be    = '0;
    lat = -1;
    ready_low = 0;
    rdata = '0;
    err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!a.req_ready) ready_low++;
      if (a.rsp_valid) begin
        lat   = c;
        rdata = a.rsp_rdata;
        err   = a.rsp_err;
        break;
      end
    end
    $display("%s: %s addr=%h be=%b wdata=%h -> rdata=%h err=%0d lat=%0d ready_low=%0d",
             tag, we ? "WR" : "RD", addr, be, wdata, rdata, err, lat, ready_low);
  endtask

  task automatic wr(input string tag, input logic [3:0] be, input logic [15:0] addr,
                    input logic [31:0] d, input int exp_lat, input logic exp_err,
                    input int exp_ready_low);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rl;
    xfer(tag, 1'b1, be, addr, d, rdata, err, lat, rl);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_ready_low"}, 32'(rl), 32'(exp_ready_low));
  endtask

  task automatic rd(input string tag, input logic [3:0] be, input logic [15:0] addr,
                    input logic [31:0] exp, input int exp_lat);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rl;
    xfer(tag, 1'b0, be, addr, 32'h0, rdata, err, lat, rl);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, err}, 32'h0);
    check({tag, "_rdata"}, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rl;
    int          seen;
    logic [31:0] exp_d;

    a.req_valid = 1'b0; a.req_we = 1'b0; a.req_be = '0; a.req_addr = '0; a.req_wdata = '0;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_be = '0; b.req_addr = '0; b.req_wdata = '0;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, a.req_ready}, 32'h0);
    check("rst_rsp_valid", {31'b0, a.rsp_valid}, 32'h0);
    check("rst_rdata", a.rsp_rdata, 32'h0);
    check("rst_err", {31'b0, a.rsp_err}, 32'h0);
    check("rst_busy", {31'b0, a.busy}, 32'h0);
    rst = 1'b0;
    #1;
    check("rel_ready", {31'b0, a.req_ready}, 32'h1);

    // 1: aligned write then read
    wr("t1_wr", 4'hF, 16'h0010, 32'hDEADBEEF, 1, 1'b0, 0);
    rd("t1_rd", 4'hF, 16'h0010, 32'hDEADBEEF, 1);

    // 2: single byte-enable write
    wr("t2_wr", 4'b0010, 16'h0010, 32'h0000AA00, 1, 1'b0, 0);
    rd("t2_rd", 4'hF, 16'h0010, 32'hDEADAAEF, 1);

    // be=0 leaves the array alone but still answers
    wr("be0_wr", 4'h0, 16'h0010, 32'hFFFFFFFF, 1, 1'b0, 0);
    rd("be0_rd", 4'hF, 16'h0010, 32'hDEADAAEF, 1);

    // 3: crossing write
    wr("t3_pre", 4'hF, 16'h0014, 32'h00000000, 1, 1'b0, 0);
`ifdef SRAM_MISALIGN_SPLIT_EN
    wr("t3_wr", 4'hF, 16'h0013, 32'h11223344, 2, 1'b0, 1);
    rd("t3_rd10", 4'hF, 16'h0010, 32'h44ADAAEF, 1);
    rd("t3_rd14", 4'hF, 16'h0014, 32'h00112233, 1);
    // misaligned non-crossing read still returns the neighbouring row bytes
    rd("mis_rd", 4'b0001, 16'h0011, 32'h3344ADAA, 1);
`else
    wr("t3_wr", 4'hF, 16'h0013, 32'h11223344, 1, 1'b1, 0);
    rd("t3_rd10", 4'hF, 16'h0010, 32'hDEADAAEF, 1);
    rd("t3_rd14", 4'hF, 16'h0014, 32'h00000000, 1);
    rd("mis_rd", 4'b0001, 16'h0011, 32'h00DEADAA, 1);
`endif

    // 4: wrap-around at the top of the address space
`ifdef SRAM_MISALIGN_SPLIT_EN
    wr("t4_wr", 4'hF, 16'hFFFE, 32'hA1B2C3D4, 2, 1'b0, 1);
    xfer("t4_rd0", 1'b0, 4'hF, 16'h0000, 32'h0, rdata, err, lat, rl);
    check("t4_rd0_lo", {16'h0, rdata[15:0]}, 32'h0000A1B2);
    check("t4_rd0_lat", 32'(lat), 32'd1);
    xfer("t4_rdfc", 1'b0, 4'hF, 16'hFFFC, 32'h0, rdata, err, lat, rl);
    check("t4_rdfc_hi", {16'h0, rdata[31:16]}, 32'h0000C3D4);
    rd("t4_rdfe", 4'hF, 16'hFFFE, 32'hA1B2C3D4, 2);
`else
    wr("t4_wr", 4'hF, 16'hFFFE, 32'hA1B2C3D4, 1, 1'b1, 0);
`endif

    // 5: RD_LAT=2 streaming on dut2 (4 writes then 4 reads, valid held)
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 8) begin
        b.req_valid = 1'b1;
        b.req_we    = (c < 4);
        b.req_be    = 4'hF;
        b.req_addr  = 16'((c % 4) * 4);
        b.req_wdata = 32'h10000001 * (c + 1);
      end else begin
        b.req_valid = 1'b0;
        b.req_be    = '0;
      end
      // response for item k shows up at iteration k+2
      if (c >= 2 && c <= 9) begin
        exp_d = (c - 2 >= 4) ? 32'h10000001 * (c - 2 - 4 + 1) : 32'h0;
        check($sformatf("t5_valid%0d", c), {31'b0, b.rsp_valid}, 32'h1);
        check($sformatf("t5_data%0d", c), b.rsp_rdata, exp_d);
        $display("t5: item=%0d rsp_valid=%0d rdata=%h busy=%0d", c - 2, b.rsp_valid, b.rsp_rdata, b.busy);
      end else begin
        check($sformatf("t5_valid%0d", c), {31'b0, b.rsp_valid}, 32'h0);
      end
      if (c >= 1 && c <= 9) check($sformatf("t5_busy%0d", c), {31'b0, b.busy}, 32'h1);
      if (c >= 11) check($sformatf("t5_busy%0d", c), {31'b0, b.busy}, 32'h0);
    end

    // 6: reset while the second beat is pending
`ifdef SRAM_MISALIGN_SPLIT_EN
    wr("t6_pre10", 4'hF, 16'h0010, 32'h00000000, 1, 1'b0, 0);
    wr("t6_pre14", 4'hF, 16'h0014, 32'h55555555, 1, 1'b0, 0);
    @(negedge clk);
    a.req_valid = 1'b1;
    a.req_we    = 1'b1;
    a.req_be    = 4'hF;
    a.req_addr  = 16'h0013;
    a.req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    a.req_valid = 1'b0;
    check("t6_beat2_ready", {31'b0, a.req_ready}, 32'h0);
    check("t6_beat2_busy", {31'b0, a.busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, a.rsp_valid}, 32'h0);
    check("t6_rst_busy", {31'b0, a.busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a.rsp_valid) seen++;
    end
    $display("t6: reset during beat 2, responses after reset=%0d", seen);
    check("t6_no_rsp", 32'(seen), 32'h0);
    rd("t6_rd10", 4'hF, 16'h0010, 32'h44000000, 1);
    rd("t6_rd14", 4'hF, 16'h0014, 32'h55555555, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
